// File: rtl/rns_pkg.sv
// Shared RNS datapath constants: default channel modulus, channel modulus list
// and the residue-width helper used to size channel logic.
package rns_pkg;

  localparam logic [31:0] DEFAULT_MOD = 32'd4294967291;

  // Pairwise-coprime channel moduli (largest primes below 2**32).
  localparam int NUM_CH = 4;
  localparam logic [NUM_CH-1:0][31:0] RNS_MODS = {
    32'd4294967197, 32'd4294967231, 32'd4294967279, 32'd4294967291
  };

  function automatic int ch_bw(input logic [31:0] mod);
    return $clog2(mod);
  endfunction

  function automatic logic [31:0] ch_mod(input int ch);
    return RNS_MODS[ch];
  endfunction

endpackage

// File: rtl/mod_sub_pipe_if.sv
// Operand/result handshake bundle for one RNS channel subtractor.
interface mod_sub_pipe_if #(
  parameter int W = 32
);
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] Z;
  logic         ERR;

  modport master (
    output IN_VALID, A, B, OUT_READY,
    input  IN_READY, OUT_VALID, Z, ERR
  );

  modport slave (
    input  IN_VALID, A, B, OUT_READY,
    output IN_READY, OUT_VALID, Z, ERR
  );
endinterface

// File: rtl/pipe_stage.sv
// One valid/ready register slice; ready passes combinationally from downstream
// so a full pipe still moves one item per cycle.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         v_q, v_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !v_q || out_ready;
  assign out_valid = v_q;
  assign out_data  = data_q;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    // When we can advance, the slot either takes new data or empties.
    if (in_ready) v_d = in_valid;
    if (in_valid && in_ready) data_d = in_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage modular subtractor Z = (A - B) mod MOD with valid/ready flow control.
// Stage 1 forms the raw difference and borrow; stage 2 folds MOD back in on borrow.
module mod_sub_pipe
  import rns_pkg::*;
#(
  parameter  logic [31:0] MOD   = DEFAULT_MOD,
  localparam int          CH_BW = ch_bw(MOD)
) (
  input  logic          CLK,
  input  logic          RST_N,
  mod_sub_pipe_if.slave io
);
  localparam int W1 = CH_BW + 2;
  localparam int W2 = CH_BW + 1;
  localparam logic [CH_BW-1:0] MOD_T = MOD[CH_BW-1:0];

  logic [CH_BW:0]   diff;
  logic             op_err;
  logic [W1-1:0]    s1_in, s1_out;
  logic             s1_vld, adv2;
  logic [CH_BW-1:0] s1_d, z_fix;
  logic             s1_borrow, s1_err;
  logic [W2-1:0]    s2_in, s2_out;

  // Stage 1 payload is {e, borrow, D}; the borrow is the top bit of diff.
  always_comb begin
    diff   = {1'b0, io.A} - {1'b0, io.B};
    op_err = (io.A >= MOD_T) || (io.B >= MOD_T);
    s1_in  = {op_err, diff};
  end

  assign {s1_err, s1_borrow, s1_d} = s1_out;
  assign z_fix = s1_borrow ? (s1_d + MOD_T) : s1_d;
  assign s2_in = {s1_err, z_fix};

  pipe_stage #(.W(W1)) u_s1 (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (io.IN_VALID),
    .in_ready  (io.IN_READY),
    .in_data   (s1_in),
    .out_valid (s1_vld),
    .out_ready (adv2),
    .out_data  (s1_out)
  );

  pipe_stage #(.W(W2)) u_s2 (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (s1_vld),
    .in_ready  (adv2),
    .in_data   (s2_in),
    .out_valid (io.OUT_VALID),
    .out_ready (io.OUT_READY),
    .out_data  (s2_out)
  );

  assign {io.ERR, io.Z} = s2_out;
endmodule

// File: tb/tb_mod_sub_pipe.sv
// Self-checking bench for mod_sub_pipe: directed scenarios plus a randomized
// scoreboard against (A - B + MOD) % MOD.
module tb_mod_sub_pipe;
  localparam logic [31:0] MOD  = 32'd4294967291;
  localparam longint      MODL = 64'd4294967291;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_vec = 0;
  int   n_bad = 0;

  mod_sub_pipe_if #(.W(32)) io();

  mod_sub_pipe #(.MOD(MOD)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .io    (io)
  );

  always #5 CLK = ~CLK;

  // Reference: subtract, wrap by MOD on borrow, keep 32 bits; ERR if an operand >= MOD.
  function automatic logic [32:0] ref_sub(input longint a, input longint b);
    longint z;
    logic   e;
    e = (a >= MODL) || (b >= MODL);
    z = (a >= b) ? (a - b) : (a - b + MODL);
    z = z & 64'hFFFF_FFFF;
    return {e, z[31:0]};
  endfunction

  function automatic logic [31:0] pick_operand();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'd0;
    if (r == 1) return MOD - 32'd1;
    return $urandom_range(0, 32'd4294967290);
  endfunction

  // Inputs change just after the falling edge; the window before the next
  // rising edge is where outputs and handshakes are observed.
  task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy);
    @(negedge CLK);
    io.IN_VALID  = iv;
    io.A         = a;
    io.B         = b;
    io.OUT_READY = ordy;
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    io.IN_VALID = 1'b0; io.A = '0; io.B = '0; io.OUT_READY = 1'b0;
    #3;
    n_vec++;
    if ({io.OUT_VALID, io.ERR, io.Z} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_state: ov=%0b err=%0b z=%0d, want all 0", io.OUT_VALID, io.ERR, io.Z);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    n_vec++;
    if (io.IN_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: in_ready=%0b, want 1", io.IN_READY);
    end
  endtask

  task automatic test_single(input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ez);
    drive(1'b1, a, b, 1'b1);
    n_vec++;
    if (io.IN_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_accept: in_ready=%0b, want 1", nm, io.IN_READY);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    n_vec++;
    if (io.OUT_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_early: out_valid=%0b one edge after accept, want 0", nm, io.OUT_VALID);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    n_vec++;
    if (io.OUT_VALID !== 1'b1 || io.Z !== ez || io.ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_result: ov=%0b z=%0d err=%0b, want ov=1 z=%0d err=0",
               nm, io.OUT_VALID, io.Z, io.ERR, ez);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [3] = '{32'd10, 32'd1, 32'd5};
    logic [31:0] bv [3] = '{32'd1, 32'd10, 32'd5};
    logic [31:0] ez [3] = '{32'd9, 32'd4294967282, 32'd0};
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, (i < 3) ? av[i] : 32'd0, (i < 3) ? bv[i] : 32'd0, 1'b1);
      if (i >= 2 && i < 5) begin
        n_vec++;
        if (io.OUT_VALID !== 1'b1 || io.Z !== ez[i-2] || io.IN_READY !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_%0d: ov=%0b z=%0d in_ready=%0b, want ov=1 z=%0d in_ready=1",
                   i - 2, io.OUT_VALID, io.Z, io.IN_READY, ez[i-2]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic        iv   [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] av   [8] = '{100, 30, 9, 55, 9, 0, 0, 0};
    logic [31:0] bv   [8] = '{30, 100, 2, 5, 2, 0, 0, 0};
    logic        ordy [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic        e_ir [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    logic        e_ov [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
    logic [31:0] e_z  [8] = '{0, 0, 70, 70, 70, 32'd4294967221, 7, 0};
    int acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(iv[i], av[i], bv[i], ordy[i]);
      if (i < 4 && io.IN_VALID && io.IN_READY) acc++;
      n_vec++;
      if (io.IN_READY !== e_ir[i] || io.OUT_VALID !== e_ov[i] ||
          (e_ov[i] && io.Z !== e_z[i])) begin
        n_bad++;
        $display("FAIL stall_w%0d: in_ready=%0b ov=%0b z=%0d, want in_ready=%0b ov=%0b z=%0d",
                 i, io.IN_READY, io.OUT_VALID, io.Z, e_ir[i], e_ov[i], e_z[i]);
      end
    end
    n_vec++;
    if (acc != 2) begin
      n_bad++;
      $display("FAIL stall_accept_count: accepted=%0d while stalled, want 2", acc);
    end
  endtask

  task automatic test_reset_inflight();
    drive(1'b1, 32'd7, 32'd3, 1'b1);
    drive(1'b1, 32'd8, 32'd3, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    n_vec++;
    if (io.OUT_VALID !== 1'b1 || io.Z !== 32'd4) begin
      n_bad++;
      $display("FAIL inflight_pre: ov=%0b z=%0d, want ov=1 z=4", io.OUT_VALID, io.Z);
    end
    #1 RST_N = 1'b0;
    #1;
    n_vec++;
    if (io.OUT_VALID !== 1'b0 || io.Z !== 32'd0 || io.ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: ov=%0b z=%0d err=%0b, want all 0", io.OUT_VALID, io.Z, io.ERR);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      n_vec++;
      if (io.OUT_VALID !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_emit_%0d: out_valid=%0b, want 0", i, io.OUT_VALID);
      end
    end
  endtask

  task automatic test_err();
    logic [32:0] e0, e1;
    e0 = ref_sub(MODL, 0);
    e1 = ref_sub(5, 2);
    drive(1'b1, MOD, 32'd0, 1'b1);
    drive(1'b1, 32'd5, 32'd2, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    n_vec++;
    if (io.OUT_VALID !== 1'b1 || {io.ERR, io.Z} !== e0) begin
      n_bad++;
      $display("FAIL err_flag: ov=%0b err=%0b z=%0d, want ov=1 err=%0b z=%0d",
               io.OUT_VALID, io.ERR, io.Z, e0[32], e0[31:0]);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    n_vec++;
    if (io.OUT_VALID !== 1'b1 || {io.ERR, io.Z} !== e1) begin
      n_bad++;
      $display("FAIL err_clear: ov=%0b err=%0b z=%0d, want ov=1 err=%0b z=%0d",
               io.OUT_VALID, io.ERR, io.Z, e1[32], e1[31:0]);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    logic [32:0] exp_v;
    logic [31:0] pa = '0, pb = '0;
    logic        pend = 1'b0;
    longint      zl;
    int          acc = 0;
    for (int cyc = 0; cyc < 20000 && (acc < 1000 || q.size() != 0); cyc++) begin
      if (acc < 1000 && !pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pa   = pick_operand();
        pb   = pick_operand();
      end
      drive(pend, pa, pb, (acc >= 1000) || ($urandom_range(0, 3) != 0));
      if (io.OUT_VALID && io.OUT_READY) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_spurious: z=%0d with nothing outstanding", io.Z);
        end else begin
          exp_v = q.pop_front();
          if ({io.ERR, io.Z} !== exp_v) begin
            n_bad++;
            $display("FAIL rand_result: err=%0b z=%0d, want err=%0b z=%0d",
                     io.ERR, io.Z, exp_v[32], exp_v[31:0]);
          end
        end
      end
      if (io.IN_VALID && io.IN_READY) begin
        zl = (longint'(pa) - longint'(pb) + MODL) % MODL;
        q.push_back({1'b0, zl[31:0]});
        pend = 1'b0;
        acc++;
      end
    end
    n_vec++;
    if (acc != 1000 || q.size() != 0) begin
      n_bad++;
      $display("FAIL rand_complete: accepted=%0d outstanding=%0d, want 1000 and 0", acc, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single("sub_7_3", 32'd7, 32'd3, 32'd4);
    test_single("sub_3_7", 32'd3, 32'd7, 32'd4294967287);
    test_single("sub_0_max", 32'd0, 32'd4294967290, 32'd1);
    test_single("sub_eq", 32'd123, 32'd123, 32'd0);
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
